blk_rep: RTL and testbench
==========================

Name: blk_rep

Overview:
- Transmit-side counterpart of the sounder RX block averager.
- Stores one sounding block of L words in BRAM, then replays it back-to-back M times, or continuously, toward the radio TX path.
- Optional per-component arithmetic attenuation; downstream valid/ready handshake.
- Sits in the sounder TX RFnoc block between the CTRL-loaded sequence buffer and the radio output stream.

Parameters:
- DWIDTH, 32: bits per item (16-bit I in [31:16], 16-bit Q in [15:0]).
- AWIDTH, 10: BRAM address width; max block length 2^AWIDTH words.
- NIPC, 1: items per word; legal values 1, 2, 4; one bram_mem per item.

Ports:
- clk  in  1  block clock.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  load mode request (level).
- din  in  DWIDTH*NIPC  load data.
- vin  in  1  load data valid.
- en  in  1  playback request (level).
- l  in  AWIDTH  block length in words; 0 means 2^AWIDTH.
- m  in  8  repetitions per burst; 0 means continuous.
- k  in  4  arithmetic right shift applied to each 16-bit I/Q component.
- dout  out  DWIDTH*NIPC  output data.
- vout  out  1  output valid.
- ordy  in  1  downstream ready.
- eob  out  1  qualifies dout as the last word of a block.
- loaded  out  1  a complete block is stored.
- busy  out  1  state is not S_IDLE.
- done  out  1  one-cycle pulse when a finite burst has fully drained.

Behaviour:
- Reset (async): state=S_IDLE; all counters=0; vout, eob, loaded, busy, done=0; pipeline valids=0. dout value is don't-care. BRAM contents are not cleared.
- States: S_IDLE, S_LOAD, S_PLAY, S_DRAIN.
- S_IDLE:
  - wr_en=1 -> S_LOAD: wcnt=0, loaded=0, l latched.
  - else en=1 & loaded=1 -> S_PLAY: rcnt=0, bcnt=0, m and k latched.
  - wr_en has priority over en when both are high.
- S_LOAD:
  - Each cycle with vin=1 writes din to address wcnt, then wcnt++.
  - The write at wcnt==l_lat-1 sets loaded=1 and moves to S_IDLE; further vin in that cycle is ignored.
  - wr_en=0 before completion aborts: loaded stays 0, go to S_IDLE.
  - vin is ignored in all other states.
- Pipeline advance: adv = !vout | ordy. BRAM en = adv, so read data holds during a stall.
  - Stage A: issue read address rcnt with va=1.
  - Stage B: BRAM output, vb.
  - Stage C: output register, which applies the shift and drives vout.
- Latency: first vout rises 2 cycles after entering S_PLAY if ordy=1 throughout.
- Stall behaviour: when vout=1 & ordy=0, dout, vout and eob are held stable and no address advances. No word may be dropped or duplicated.
- S_PLAY, address and block counting:
  - On each adv, rcnt++ and wraps from l_lat-1 to 0. eob travels with the word read at address l_lat-1.
  - Each wrap increments bcnt (8-bit).
- S_PLAY, stop conditions:
  - When the address l_lat-1 issued completes block bcnt==m_lat-1 (m_lat!=0), stop issuing and go to S_DRAIN.
  - If en=0 is sampled, the current block finishes (through address l_lat-1), then go to S_DRAIN. Partial blocks are never emitted.
  - If m_lat=0, play continues until en=0.
- S_DRAIN: no new reads. When the pipeline is empty (va, vb and vout all 0 after the final handshake), pulse done for 1 cycle and go to S_IDLE.
- Scaling: each signed 16-bit component is shifted right arithmetically by k_lat (sign-extending). k=15 yields 0 or -1. k=0 is pass-through.
- Input sampling: l, m and k are sampled only on state entry; changes mid-operation have no effect.
- Single-word block: l=1 outputs the same word with eob=1 on every beat.
- wr_en rising during S_PLAY or S_DRAIN is ignored until S_IDLE is reached.
- Reset mid-operation: immediate return to S_IDLE, vout drops at once, loaded=0.

Test Plan:
- Load l=4 with words 0x00010002, 0x00030004, 0x00050006, 0x00070008; m=2, k=0, en=1, ordy=1 -> 8 consecutive vout beats replaying the 4 words twice; eob on beats 4 and 8; done pulses 1 cycle after the last handshake; first vout 2 cycles after S_PLAY entry.
- Same load with k=1 and a word of 0x8000FFFE -> I=0xC000, Q=0xFFFF; positive 0x00070008 -> 0x00030004.
- m=0 continuous with ordy toggled at random 50% -> output stream is an exact periodic repetition of the 4 words; held values during ordy=0 are stable. Drop en mid-block at address 1 -> output continues through address 3, eob=1, then done.
- Abort load: wr_en drops after 2 of 4 vin writes -> loaded=0; asserting en then produces no output and busy stays 0.
- l=1, m=3 -> 3 beats, each with eob=1. l=0 with AWIDTH=10 -> 1024-word block, address wraps correctly.
- Async reset asserted mid-S_PLAY while vout=1 and ordy=0 -> vout=0 and loaded=0 immediately. Same run with NIPC=4 -> each of the 4 lanes is scaled independently.

Source files
------------

// File: rtl/blk_rep.sv
`default_nettype none
// ============================================================================
//  Module   : blk_rep
//  Purpose  : Sounder TX block repeater. Stores one sounding block of L words
//             in BRAM, then replays it back-to-back M times (or continuously)
//             with optional per-component arithmetic attenuation, toward a
//             valid/ready output stream.
//  Revision : 1.0  initial release
// ============================================================================
module blk_rep #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 10,
    parameter int NIPC   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DWIDTH*NIPC-1:0]   din,
    input  logic                     vin,
    input  logic                     en,
    input  logic [AWIDTH-1:0]        l,
    input  logic [7:0]               m,
    input  logic [3:0]               k,
    output logic [DWIDTH*NIPC-1:0]   dout,
    output logic                     vout,
    input  logic                     ordy,
    output logic                     eob,
    output logic                     loaded,
    output logic                     busy,
    output logic                     done
);

    localparam int DW = DWIDTH * NIPC;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_PLAY  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              state_q,  state_d;
    logic [AWIDTH-1:0]   wcnt_q,   wcnt_d;
    logic [AWIDTH-1:0]   rcnt_q,   rcnt_d;
    logic [AWIDTH-1:0]   l_lat_q,  l_lat_d;
    logic [7:0]          bcnt_q,   bcnt_d;
    logic [7:0]          m_lat_q,  m_lat_d;
    logic [3:0]          k_lat_q,  k_lat_d;
    logic                stop_q,   stop_d;
    logic                loaded_q, loaded_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic                vb_q,     vb_d;
    logic                eb_q,     eb_d;
    logic                vout_q,   vout_d;
    logic                eob_q,    eob_d;
    logic [DW-1:0]       dout_q,   dout_d;

    logic                w_adv;
    logic                w_va;
    logic                w_last_addr;
    logic                w_mem_we;
    logic [AWIDTH-1:0]   w_l_last;
    logic [DW-1:0]       w_scaled;

    // The whole pipeline (BRAM read register included) only moves when the
    // output register is empty or being consumed, so a stall freezes it.
    assign w_adv       = !vout_q || ordy;
    assign w_va        = (state_q == S_PLAY);
    // l_lat = 0 naturally wraps to the all-ones address, i.e. a 2^AWIDTH block.
    assign w_l_last    = l_lat_q - AWIDTH'(1);
    assign w_last_addr = (rcnt_q == w_l_last);
    assign w_mem_we    = (state_q == S_LOAD) && wr_en && vin;

    // One BRAM per item lane, each followed by its own I/Q scaler.
    for (genvar gi = 0; gi < NIPC; gi++) begin : g_lane
        logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];
        logic [DWIDTH-1:0] rd_q;
        logic [DWIDTH-1:0] lane_s;

        // Write port fed from the load stream, read port enabled by advance.
        always_ff @(posedge clk) begin
            if (w_mem_we) begin
                mem[wcnt_q] <= din[gi*DWIDTH +: DWIDTH];
            end
            if (w_adv) begin
                rd_q <= mem[rcnt_q];
            end
        end

        // Sign-extending right shift of the I (upper) and Q (lower) halves.
        always_comb begin
            lane_s              = rd_q;
            lane_s[DWIDTH-1 -: 16] = $signed(rd_q[DWIDTH-1 -: 16]) >>> k_lat_q;
            lane_s[15:0]        = $signed(rd_q[15:0]) >>> k_lat_q;
        end

        assign w_scaled[gi*DWIDTH +: DWIDTH] = lane_s;
    end

    // Next-state logic for the control FSM, counters and the read pipeline.
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        rcnt_d   = rcnt_q;
        l_lat_d  = l_lat_q;
        bcnt_d   = bcnt_q;
        m_lat_d  = m_lat_q;
        k_lat_d  = k_lat_q;
        stop_d   = stop_q;
        loaded_d = loaded_q;
        done_d   = 1'b0;
        vb_d     = vb_q;
        eb_d     = eb_q;
        vout_d   = vout_q;
        eob_d    = eob_q;
        dout_d   = dout_q;

        if (w_adv) begin
            vb_d   = w_va;
            eb_d   = w_va && w_last_addr;
            vout_d = vb_q;
            eob_d  = eb_q;
            dout_d = w_scaled;
        end

        case (state_q)
            S_IDLE: begin
                if (wr_en) begin
                    state_d  = S_LOAD;
                    wcnt_d   = '0;
                    loaded_d = 1'b0;
                    l_lat_d  = l;
                end else if (en && loaded_q) begin
                    state_d = S_PLAY;
                    rcnt_d  = '0;
                    bcnt_d  = '0;
                    m_lat_d = m;
                    k_lat_d = k;
                    stop_d  = 1'b0;
                end
            end
            S_LOAD: begin
                if (!wr_en) begin
                    state_d = S_IDLE;
                end else if (vin) begin
                    wcnt_d = wcnt_q + AWIDTH'(1);
                    if (wcnt_q == w_l_last) begin
                        loaded_d = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end
            S_PLAY: begin
                // A dropped en is remembered so the block in flight completes.
                if (!en) begin
                    stop_d = 1'b1;
                end
                if (w_adv) begin
                    if (w_last_addr) begin
                        rcnt_d = '0;
                        bcnt_d = bcnt_q + 8'd1;
                        if (stop_q || !en ||
                            ((m_lat_q != 8'd0) && (bcnt_q == m_lat_q - 8'd1))) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        rcnt_d = rcnt_q + AWIDTH'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (!vb_q && !vout_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wcnt_q   <= '0;
            rcnt_q   <= '0;
            l_lat_q  <= '0;
            bcnt_q   <= '0;
            m_lat_q  <= '0;
            k_lat_q  <= '0;
            stop_q   <= 1'b0;
            loaded_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            vb_q     <= 1'b0;
            eb_q     <= 1'b0;
            vout_q   <= 1'b0;
            eob_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            rcnt_q   <= rcnt_d;
            l_lat_q  <= l_lat_d;
            bcnt_q   <= bcnt_d;
            m_lat_q  <= m_lat_d;
            k_lat_q  <= k_lat_d;
            stop_q   <= stop_d;
            loaded_q <= loaded_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            vb_q     <= vb_d;
            eb_q     <= eb_d;
            vout_q   <= vout_d;
            eob_q    <= eob_d;
            dout_q   <= dout_d;
        end
    end

    assign dout   = dout_q;
    assign vout   = vout_q;
    assign eob    = eob_q;
    assign loaded = loaded_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_blk_rep.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_blk_rep
//  Purpose  : Self-checking bench for blk_rep. Two instances (NIPC=1 and
//             NIPC=4) share all control inputs; a scoreboard queue of
//             expected beats is filled when playback is launched and drained
//             by a monitor at every output handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_blk_rep;

    localparam int AW = 10;

    typedef struct {
        logic [127:0] data;
        logic         eob;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, wr_en, vin, en, ordy;
    logic [127:0]  din4;
    logic [AW-1:0] l;
    logic [7:0]    m;
    logic [3:0]    k;
    logic [31:0]   dout1;
    logic [127:0]  dout4;
    logic          vout1, eob1, loaded1, busy1, done1;
    logic          vout4, eob4, loaded4, busy4, done4;

    exp_t          exp_q[$];
    logic [127:0]  img [0:1023];
    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            pops = 0;
    int            last_pop_cyc = 0;
    int            done_cyc = -1;
    bit            stall_prev = 1'b0;
    logic [31:0]   hold_d;
    logic          hold_e;

    always #5 clk = ~clk;

    blk_rep #(.DWIDTH(32), .AWIDTH(AW), .NIPC(1)) u_dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din4[31:0]), .vin(vin),
        .en(en), .l(l), .m(m), .k(k), .dout(dout1), .vout(vout1),
        .ordy(ordy), .eob(eob1), .loaded(loaded1), .busy(busy1), .done(done1)
    );

    blk_rep #(.DWIDTH(32), .AWIDTH(AW), .NIPC(4)) u_dut4 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din4), .vin(vin),
        .en(en), .l(l), .m(m), .k(k), .dout(dout4), .vout(vout4),
        .ordy(ordy), .eob(eob4), .loaded(loaded4), .busy(busy4), .done(done4)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference scaler: arithmetic right shift of every 16-bit component.
    function automatic logic [127:0] scale(input logic [127:0] x, input int kk);
        logic [127:0] r;
        for (int j = 0; j < 8; j++) begin
            r[16*j +: 16] = 16'($signed(x[16*j +: 16]) >>> kk);
        end
        return r;
    endfunction

    task automatic push(input int n, input int reps, input int kk);
        exp_t e;
        for (int r = 0; r < reps; r++) begin
            for (int a = 0; a < n; a++) begin
                e.data = scale(img[a], kk);
                e.eob  = (a == n - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n);
        tick();
        wr_en = 1'b1;
        l     = n[AW-1:0];
        vin   = 1'b0;
        tick();
        for (int i = 0; i < n; i++) begin
            vin  = 1'b1;
            din4 = img[i];
            tick();
        end
        vin   = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic play(input int mm, input int kk);
        tick();
        en = 1'b1;
        m  = mm[7:0];
        k  = kk[3:0];
    endtask

    task automatic wait_done(input string tag, input int budget, input bit rnd);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (rnd) ordy = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done1) begin
                got = 1'b1;
                en  = 1'b0;
                break;
            end
        end
        #1;
        ordy = 1'b1;
        tests++;
        assert (got) else begin
            fails++;
            $error("FAIL %s_timeout observed=no_done expected=done", tag);
        end
        if (got) chk({tag, "_done_lat"}, done_cyc - last_pop_cyc, 2);
        chk({tag, "_left"}, exp_q.size(), 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done1, 1'b0);
        chk({tag, "_busy_idle"}, busy1, 1'b0);
    endtask

    always @(posedge clk) cyc++;

    // Output monitor: scoreboard pop on each handshake, hold check on stall.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_vout", vout1, 1'b1);
                chk("hold_dout", dout1, hold_d);
                chk("hold_eob", eob1, hold_e);
            end
            if (vout1 && ordy) begin
                tests++;
                assert (exp_q.size() != 0) else begin
                    fails++;
                    $error("FAIL extra_beat observed=%h expected=none", dout1);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("dout1", dout1, e.data[31:0]);
                    chk("dout4", dout4, e.data);
                    chk("eob1", eob1, e.eob);
                    chk("eob4", eob4, e.eob);
                    pops++;
                    last_pop_cyc = cyc;
                end
            end
            stall_prev = vout1 && !ordy;
            hold_d     = dout1;
            hold_e     = eob1;
            if (done1) done_cyc = cyc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int base;
        bit flag;

        rst = 1'b1; wr_en = 1'b0; vin = 1'b0; en = 1'b0; ordy = 1'b1;
        din4 = '0; l = '0; m = '0; k = '0;
        img[0] = 128'h7FFF1234_80000001_FFFF0010_00010002;
        img[1] = 128'h00FF8000_12345678_F0F00F0F_00030004;
        img[2] = 128'h80007FFF_FFFF8001_0001FFFF_00050006;
        img[3] = 128'h40004000_C000C000_00000001_00070008;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_vout", vout1, 1'b0);
        chk("rst_loaded", loaded1, 1'b0);
        chk("rst_busy", busy4, 1'b0);
        chk("rst_done", done1, 1'b0);
        tick();
        rst = 1'b0;

        // Basic replay: l=4, m=2, k=0
        load(4);
        chk("t1_loaded1", loaded1, 1'b1);
        chk("t1_loaded4", loaded4, 1'b1);
        push(4, 2, 0);
        base = pops;
        play(2, 0);
        c0 = cyc;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (vout1) break;
        end
        chk("t1_first_vout_lat", cyc - c0, 3);
        wait_done("t1", 50, 1'b0);
        chk("t1_beats", pops - base, 8);

        // Attenuation k=1 with a negative I component
        img[2][31:0] = 32'h8000FFFE;
        load(4);
        push(4, 1, 1);
        play(1, 1);
        wait_done("t2", 50, 1'b0);

        // Continuous play with random backpressure, en dropped mid-block
        load(4);
        push(4, 5, 2);
        base = pops;
        play(0, 2);
        for (int i = 0; i < 400; i++) begin
            tick();
            if (pops - base >= 17) begin
                en = 1'b0;
                break;
            end
            ordy = 1'($urandom_range(0, 1));
        end
        wait_done("t3", 200, 1'b1);
        chk("t3_beats", pops - base, 20);

        // Aborted load: no playback afterwards
        tick();
        wr_en = 1'b1; l = AW'(4);
        tick();
        vin = 1'b1; din4 = img[0];
        tick();
        din4 = img[1];
        tick();
        vin = 1'b0; wr_en = 1'b0;
        tick();
        chk("t4_loaded1", loaded1, 1'b0);
        chk("t4_loaded4", loaded4, 1'b0);
        en = 1'b1; m = 8'd1;
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy1 || vout1) flag = 1'b1;
        end
        chk("t4_no_play", flag, 1'b0);
        #1 en = 1'b0;

        // Single-word block, three repetitions
        img[0] = 128'h0BAD0001_F00D0002_C0DE0003_12345678;
        load(1);
        push(1, 3, 0);
        base = pops;
        play(3, 0);
        wait_done("t5", 50, 1'b0);
        chk("t5_beats", pops - base, 3);

        // l=0: full 1024-word block, two passes to cross the address wrap
        for (int i = 0; i < 1024; i++) begin
            img[i] = {32'(i) * 32'h01000193 ^ 32'hDEADBEEF, 32'(i) + 32'h100,
                      ~32'(i), (32'(i) << 3) ^ 32'h80008000};
        end
        load(1024);
        chk("t6_loaded", loaded1, 1'b1);
        push(1024, 2, 0);
        base = pops;
        play(2, 0);
        wait_done("t6", 2200, 1'b0);
        chk("t6_beats", pops - base, 2048);

        // Asynchronous reset while a beat is stalled at the output
        img[0] = 128'h11112222_33334444_55556666_77778888;
        load(4);
        ordy = 1'b0;
        play(0, 0);
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (vout1) begin
                flag = 1'b1;
                break;
            end
        end
        chk("t7_stalled_vout", flag, 1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t7_vout1", vout1, 1'b0);
        chk("t7_vout4", vout4, 1'b0);
        chk("t7_loaded1", loaded1, 1'b0);
        chk("t7_loaded4", loaded4, 1'b0);
        chk("t7_busy", busy1, 1'b0);
        en = 1'b0;
        tick();
        tick();
        rst  = 1'b0;
        ordy = 1'b1;
        repeat (3) tick();
        chk("t7_after_vout", vout1, 1'b0);
        chk("final_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
